// File: rtl/guess_controller.sv
// guess_controller: letter-guessing game sequencer for a 5-letter secret word.
// Accepts one ASCII guess at a time, reports hit mask / mistake pulses and
// tracks revealed positions and mistakes until a win or a loss.
// Optional build macro: GUESS_DUP_FILTER_EN adds a used-letter mask that
// rejects a letter that was already accepted in the current game.
module guess_controller (
    input  logic        clk,
    input  logic        nRst,
    input  logic        new_game,
    input  logic [39:0] word_in,
    input  logic        guess_valid,
    input  logic [7:0]  guess_letter,
    output logic        guess_ready,
    output logic        guess_reject,
    output logic [7:0]  letter,
    output logic [4:0]  indexCorrect,
    output logic        mistake,
    output logic [2:0]  numMistake,
    output logic [2:0]  correct,
    output logic        gameEnd_host,
    output logic        win,
    output logic        lose
);

    localparam int unsigned CHAR_W      = 8;
    localparam int unsigned NPOS        = 5;
    localparam int unsigned CNT_W       = 3;
    localparam int unsigned MAX_MISTAKE = 6;
    localparam logic [7:0]  ASCII_A     = 8'h41;
    localparam logic [7:0]  ASCII_Z     = 8'h5A;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        PLAY   = 3'd2,
        CHECK  = 3'd3,
        UPDATE = 3'd4,
        WIN    = 3'd5,
        LOSE   = 3'd6
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [NPOS*CHAR_W-1:0] word_q;
    logic [NPOS-1:0]     revealed;
    logic [NPOS-1:0]     hit_c;
    logic                accept_c;
    logic                alpha_c;
    logic                dup_c;
    logic                reject_d;
    logic [NPOS-1:0]     index_d;
    logic                mistake_d;
    logic                clear_d;
    logic                win_d;
    logic                lose_d;
    logic [CNT_W-1:0]    correct_upd_c;
    logic [CNT_W-1:0]    mistake_upd_c;

    function automatic logic [CNT_W-1:0] popcount5(input logic [NPOS-1:0] v);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int i = 0; i < NPOS; i++) s = s + CNT_W'(v[i]);
        return s;
    endfunction

    // A guess is taken only in PLAY and never alongside a new_game request
    assign accept_c = guess_valid && (state == PLAY) && !new_game;
    assign alpha_c  = (guess_letter >= ASCII_A) && (guess_letter <= ASCII_Z);

`ifdef GUESS_DUP_FILTER_EN
    logic [25:0] used;
    logic [4:0]  guess_idx_c;
    logic [4:0]  check_idx_c;

    // Letter-to-mask index; non-letters map to 0 and are rejected anyway
    always_comb begin
        guess_idx_c = alpha_c ? 5'(guess_letter - ASCII_A) : 5'd0;
        check_idx_c = ((letter >= ASCII_A) && (letter <= ASCII_Z)) ? 5'(letter - ASCII_A) : 5'd0;
        dup_c       = alpha_c && used[guess_idx_c];
    end

    // Used-letter mask: cleared on a new game, set when a guess survives CHECK
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            used <= '0;
        end else if (next_state == CLEAR) begin
            used <= '0;
        end else if ((state == CHECK) && !guess_reject) begin
            used[check_idx_c] <= 1'b1;
        end
    end
`else
    assign dup_c = 1'b0;
`endif

    // Per-position compare of the registered guess against the secret word
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < NPOS; i++) begin
            hit_c[i] = (letter == word_q[i*CHAR_W +: CHAR_W]);
        end
    end

    // Counter values that UPDATE commits
    always_comb begin
        correct_upd_c = correct + popcount5(indexCorrect & ~revealed);
        mistake_upd_c = numMistake;
        if (mistake && (numMistake != CNT_W'(MAX_MISTAKE))) begin
            mistake_upd_c = numMistake + CNT_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic; new_game overrides everything
    always_comb begin
        next_state = state;
        if (new_game) begin
            next_state = CLEAR;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                CLEAR:   next_state = PLAY;
                PLAY:    if (accept_c) next_state = CHECK;
                CHECK:   next_state = guess_reject ? PLAY : UPDATE;
                UPDATE: begin
                    if (correct_upd_c == CNT_W'(NPOS))            next_state = WIN;
                    else if (mistake_upd_c == CNT_W'(MAX_MISTAKE)) next_state = LOSE;
                    else                                           next_state = PLAY;
                end
                WIN:     next_state = WIN;
                LOSE:    next_state = LOSE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Output decode: guess_ready is combinational, the rest feed registers
    always_comb begin
        guess_ready = (state == PLAY);
        reject_d    = accept_c && (!alpha_c || dup_c);
        index_d     = (next_state == UPDATE) ? hit_c : '0;
        mistake_d   = (next_state == UPDATE) && (hit_c == '0);
        clear_d     = (next_state == CLEAR);
        win_d       = (next_state == WIN);
        lose_d      = (next_state == LOSE);
    end

    // Registered outputs, secret word and game counters
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            guess_reject <= 1'b0;
            letter       <= '0;
            indexCorrect <= '0;
            mistake      <= 1'b0;
            numMistake   <= '0;
            correct      <= '0;
            gameEnd_host <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
            word_q       <= '0;
            revealed     <= '0;
        end else begin
            guess_reject <= reject_d;
            indexCorrect <= index_d;
            mistake      <= mistake_d;
            gameEnd_host <= clear_d;
            win          <= win_d;
            lose         <= lose_d;
            if (new_game) word_q <= word_in;
            if (accept_c) letter <= guess_letter;
            if (next_state == CLEAR) begin
                numMistake <= '0;
                correct    <= '0;
                revealed   <= '0;
            end else if (state == UPDATE) begin
                numMistake <= mistake_upd_c;
                correct    <= correct_upd_c;
                revealed   <= revealed | indexCorrect;
            end
        end
    end

endmodule

// File: tb/tb_guess_controller.sv
// Directed bench for guess_controller: reset, game start, hits, misses,
// win/lose, rejects, repeated letters and reset in the middle of a guess.
module tb_guess_controller;

    logic        clk;
    logic        nRst;
    logic        new_game;
    logic [39:0] word_in;
    logic        guess_valid;
    logic [7:0]  guess_letter;
    logic        guess_ready;
    logic        guess_reject;
    logic [7:0]  letter;
    logic [4:0]  indexCorrect;
    logic        mistake;
    logic [2:0]  numMistake;
    logic [2:0]  correct;
    logic        gameEnd_host;
    logic        win;
    logic        lose;

    int total;
    int bad;

    localparam logic [39:0] HELLO = 40'h48454C4C4F;

    guess_controller dut (
        .clk          (clk),
        .nRst         (nRst),
        .new_game     (new_game),
        .word_in      (word_in),
        .guess_valid  (guess_valid),
        .guess_letter (guess_letter),
        .guess_ready  (guess_ready),
        .guess_reject (guess_reject),
        .letter       (letter),
        .indexCorrect (indexCorrect),
        .mistake      (mistake),
        .numMistake   (numMistake),
        .correct      (correct),
        .gameEnd_host (gameEnd_host),
        .win          (win),
        .lose         (lose)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input string tag);
        new_game = 1'b1;
        word_in  = HELLO;
        tick();
        new_game = 1'b0;
        check({tag, ":clr_pulse"}, 64'(gameEnd_host), 64'd1);
        check({tag, ":clr_ready"}, 64'(guess_ready), 64'd0);
        check({tag, ":clr_nm"}, 64'(numMistake), 64'd0);
        check({tag, ":clr_cor"}, 64'(correct), 64'd0);
        tick();
        check({tag, ":play_ready"}, 64'(guess_ready), 64'd1);
        check({tag, ":play_clr"}, 64'(gameEnd_host), 64'd0);
    endtask

    // Offer one guess from PLAY; leaves the bench one cycle after UPDATE
    // (or back in PLAY one cycle after CHECK for a rejected guess)
    task automatic do_guess(input string tag, input logic [7:0] g,
                            input logic exp_rej, input logic [4:0] exp_idx);
        check({tag, ":ready"}, 64'(guess_ready), 64'd1);
        guess_valid  = 1'b1;
        guess_letter = g;
        tick();
        guess_valid = 1'b0;
        check({tag, ":reject"}, 64'(guess_reject), 64'(exp_rej));
        check({tag, ":letter"}, 64'(letter), 64'(g));
        tick();
        if (exp_rej) begin
            check({tag, ":rj_idx"}, 64'(indexCorrect), 64'd0);
            check({tag, ":rj_mis"}, 64'(mistake), 64'd0);
            check({tag, ":rj_ready"}, 64'(guess_ready), 64'd1);
            check({tag, ":rj_pulse"}, 64'(guess_reject), 64'd0);
        end else begin
            check({tag, ":idx"}, 64'(indexCorrect), 64'(exp_idx));
            check({tag, ":mis"}, 64'(mistake), 64'(exp_idx == 5'd0));
            tick();
            check({tag, ":idx_off"}, 64'(indexCorrect), 64'd0);
            check({tag, ":mis_off"}, 64'(mistake), 64'd0);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        nRst         = 1'b0;
        new_game     = 1'b0;
        word_in      = '0;
        guess_valid  = 1'b0;
        guess_letter = '0;
        #12;
        check("rst:ready", 64'(guess_ready), 64'd0);
        check("rst:letter", 64'(letter), 64'd0);
        check("rst:nm", 64'(numMistake), 64'd0);
        check("rst:win", 64'(win), 64'd0);
        check("rst:lose", 64'(lose), 64'd0);
        check("rst:clr", 64'(gameEnd_host), 64'd0);
        tick();
        nRst = 1'b1;
        tick();

        // IDLE ignores guesses
        guess_valid  = 1'b1;
        guess_letter = 8'h41;
        tick();
        tick();
        guess_valid = 1'b0;
        check("idle:ready", 64'(guess_ready), 64'd0);
        check("idle:letter", 64'(letter), 64'd0);
        check("idle:reject", 64'(guess_reject), 64'd0);

        // Game 1: one hit then six misses -> LOSE
        start_game("g1");
        do_guess("g1_L", 8'h4C, 1'b0, 5'b00110);
        check("g1_L:cor", 64'(correct), 64'd2);
        check("g1_L:nm", 64'(numMistake), 64'd0);
        begin
            logic [7:0] misses [6];
            misses = '{8'h5A, 8'h51, 8'h58, 8'h56, 8'h4B, 8'h4A};
            for (int i = 0; i < 6; i++) begin
                do_guess($sformatf("g1_miss%0d", i), misses[i], 1'b0, 5'b00000);
                check($sformatf("g1_miss%0d:nm", i), 64'(numMistake), 64'(i + 1));
            end
        end
        check("g1:lose", 64'(lose), 64'd1);
        check("g1:win", 64'(win), 64'd0);
        check("g1:ready", 64'(guess_ready), 64'd0);
        guess_valid  = 1'b1;
        guess_letter = 8'h48;
        repeat (3) tick();
        guess_valid = 1'b0;
        check("g1_hold:nm", 64'(numMistake), 64'd6);
        check("g1_hold:cor", 64'(correct), 64'd2);
        check("g1_hold:lose", 64'(lose), 64'd1);
        check("g1_hold:letter", 64'(letter), 64'h4A);

        // Game 2: H, E, L, (L again), O -> WIN
        start_game("g2");
        check("g2:lose_off", 64'(lose), 64'd0);
        do_guess("g2_H", 8'h48, 1'b0, 5'b10000);
        check("g2_H:cor", 64'(correct), 64'd1);
        do_guess("g2_E", 8'h45, 1'b0, 5'b01000);
        check("g2_E:cor", 64'(correct), 64'd2);
        do_guess("g2_L", 8'h4C, 1'b0, 5'b00110);
        check("g2_L:cor", 64'(correct), 64'd4);
`ifdef GUESS_DUP_FILTER_EN
        do_guess("g2_L2", 8'h4C, 1'b1, 5'b00000);
`else
        do_guess("g2_L2", 8'h4C, 1'b0, 5'b00110);
`endif
        check("g2_L2:cor", 64'(correct), 64'd4);
        check("g2_L2:nm", 64'(numMistake), 64'd0);
        do_guess("g2_O", 8'h4F, 1'b0, 5'b00001);
        check("g2_O:cor", 64'(correct), 64'd5);
        check("g2:win", 64'(win), 64'd1);
        check("g2:ready", 64'(guess_ready), 64'd0);
        guess_valid  = 1'b1;
        guess_letter = 8'h5A;
        repeat (3) tick();
        guess_valid = 1'b0;
        check("g2_hold:win", 64'(win), 64'd1);
        check("g2_hold:cor", 64'(correct), 64'd5);
        check("g2_hold:nm", 64'(numMistake), 64'd0);
        check("g2_hold:letter", 64'(letter), 64'h4F);

        // Game 3: repeated miss, non-letter reject, new_game vs guess
        start_game("g3");
        do_guess("g3_Z1", 8'h5A, 1'b0, 5'b00000);
        check("g3_Z1:nm", 64'(numMistake), 64'd1);
`ifdef GUESS_DUP_FILTER_EN
        do_guess("g3_Z2", 8'h5A, 1'b1, 5'b00000);
        check("g3_Z2:nm", 64'(numMistake), 64'd1);
`else
        do_guess("g3_Z2", 8'h5A, 1'b0, 5'b00000);
        check("g3_Z2:nm", 64'(numMistake), 64'd2);
`endif
        do_guess("g3_dig", 8'h31, 1'b1, 5'b00000);
`ifdef GUESS_DUP_FILTER_EN
        check("g3_dig:nm", 64'(numMistake), 64'd1);
`else
        check("g3_dig:nm", 64'(numMistake), 64'd2);
`endif
        new_game     = 1'b1;
        word_in      = HELLO;
        guess_valid  = 1'b1;
        guess_letter = 8'h41;
        tick();
        new_game    = 1'b0;
        guess_valid = 1'b0;
        check("g3_ng:clr", 64'(gameEnd_host), 64'd1);
        check("g3_ng:reject", 64'(guess_reject), 64'd0);
        check("g3_ng:letter", 64'(letter), 64'h31);
        check("g3_ng:nm", 64'(numMistake), 64'd0);
        tick();
        check("g3_ng:ready", 64'(guess_ready), 64'd1);
        check("g3_ng:mis", 64'(mistake), 64'd0);

        // Reset while a guess sits in CHECK
        guess_valid  = 1'b1;
        guess_letter = 8'h5A;
        tick();
        guess_valid = 1'b0;
        nRst = 1'b0;
        #2;
        check("mid_rst:letter", 64'(letter), 64'd0);
        check("mid_rst:ready", 64'(guess_ready), 64'd0);
        check("mid_rst:reject", 64'(guess_reject), 64'd0);
        tick();
        nRst = 1'b1;
        tick();
        tick();
        check("mid_rst:mis", 64'(mistake), 64'd0);
        check("mid_rst:idx", 64'(indexCorrect), 64'd0);
        check("mid_rst:nm", 64'(numMistake), 64'd0);
        check("mid_rst:idle", 64'(guess_ready), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
